// File: rtl/crc_fcs_checker.sv
// Receive-side Ethernet FCS checker for the 64-bit AXI-Stream MAC datapath.
// Checks reflected CRC-32 on the fly, strips the 4 FCS bytes and flags bad
// frames through maxis_tuser on the output last beat.
// Optional statistics counters are built when CRC_STATS_EN is defined.
module crc_fcs_checker #(
    parameter logic [31:0] POLYNOMIAL  = 32'hEDB88320,
    parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3
`ifdef CRC_STATS_EN
    ,
    parameter int unsigned COUNTER_WIDTH = 32
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] saxis_tdata,
    input  logic        saxis_tvalid,
    output logic        saxis_tready,
    input  logic [7:0]  saxis_tkeep,
    input  logic        saxis_tlast,
    input  logic        saxis_tuser,
    output logic [63:0] maxis_tdata,
    output logic        maxis_tvalid,
    input  logic        maxis_tready,
    output logic [7:0]  maxis_tkeep,
    output logic        maxis_tlast,
    output logic        maxis_tuser,
    output logic        crc_ok,
    output logic        crc_err
`ifdef CRC_STATS_EN
    ,
    output logic [COUNTER_WIDTH-1:0] frame_count,
    output logic [COUNTER_WIDTH-1:0] crc_error_count,
    output logic [COUNTER_WIDTH-1:0] runt_count
`endif
);

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // CRC register, sticky upstream error and the one-beat hold register
    logic [31:0] r_crc;
    logic        r_sticky;
    logic        r_h_valid;
    logic [63:0] r_h_data;
    logic [7:0]  r_h_keep;
    logic        r_h_last;
    logic        r_h_err;

    logic [3:0]  w_k;
    logic [31:0] w_crc_next;
    logic        w_crc_bad;
    logic        w_err;
    logic        w_short;
    logic        w_fold;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_runt;

    // LSB-first CRC update over the kept bytes of one beat
    function automatic logic [31:0] crc_bytes(input logic [31:0] c_in,
                                              input logic [63:0] d,
                                              input logic [7:0]  k);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) begin
                c = c ^ {24'd0, d[b*8 +: 8]};
                for (int i = 0; i < 8; i++) begin
                    c = c[0] ? ((c >> 1) ^ POLYNOMIAL) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    // Number of valid bytes in a keep vector
    function automatic logic [3:0] keep_count(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(k[i]);
        end
        return n;
    endfunction

    // Contiguous keep mask of n bytes (n in 0..8)
    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        return 8'hFF >> (4'd8 - n);
    endfunction

    // Beat classification and next CRC for the beat currently offered
    always_comb begin
        w_k        = keep_count(saxis_tkeep);
        w_crc_next = crc_bytes(r_crc, saxis_tdata, saxis_tkeep);
        w_crc_bad  = (w_crc_next != CRC_RESIDUE);
        w_err      = w_crc_bad | r_sticky | saxis_tuser;
        w_short    = (w_k <= 4'd4);
        // last beat holding only FCS bytes: H itself becomes the output last beat
        w_fold     = r_h_valid && !r_h_last && saxis_tvalid && saxis_tlast && w_short;
    end

    // Handshake and output beat selection
    always_comb begin
        saxis_tready = !r_h_valid || maxis_tready;
        maxis_tvalid = r_h_valid && (r_h_last || saxis_tvalid);
        maxis_tdata  = r_h_data;
        maxis_tkeep  = w_fold ? keep_mask(w_k + 4'd4) : r_h_keep;
        maxis_tlast  = r_h_last | w_fold;
        maxis_tuser  = w_fold ? w_err : r_h_err;
        w_in_xfer    = saxis_tvalid && saxis_tready;
        w_out_xfer   = maxis_tvalid && maxis_tready;
        crc_ok       = w_out_xfer && maxis_tlast && !maxis_tuser;
        crc_err      = w_out_xfer && maxis_tlast && maxis_tuser;
        // a frame of at most 4 bytes never reaches the output
        w_runt       = w_in_xfer && saxis_tlast && w_short && !(r_h_valid && !r_h_last);
    end

    // CRC, sticky error and hold register update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crc     <= CRC_INIT;
            r_sticky  <= 1'b0;
            r_h_valid <= 1'b0;
            r_h_data  <= 64'd0;
            r_h_keep  <= 8'd0;
            r_h_last  <= 1'b0;
            r_h_err   <= 1'b0;
        end else if (w_in_xfer) begin
            if (saxis_tlast) begin
                r_crc    <= CRC_INIT;
                r_sticky <= 1'b0;
            end else begin
                r_crc    <= w_crc_next;
                r_sticky <= r_sticky | saxis_tuser;
            end
            if (!saxis_tlast || !w_short) begin
                r_h_valid <= 1'b1;
                r_h_data  <= saxis_tdata;
                r_h_keep  <= saxis_tlast ? keep_mask(w_k - 4'd4) : saxis_tkeep;
                r_h_last  <= saxis_tlast;
                r_h_err   <= saxis_tlast & w_err;
            end else begin
                r_h_valid <= 1'b0;
            end
        end else if (w_out_xfer) begin
            r_h_valid <= 1'b0;
        end
    end

`ifdef CRC_STATS_EN
    // Wrapping frame, CRC error and runt counters
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count     <= '0;
            crc_error_count <= '0;
            runt_count      <= '0;
        end else begin
            if (w_out_xfer && maxis_tlast) frame_count <= frame_count + 1'b1;
            if (crc_err)                   crc_error_count <= crc_error_count + 1'b1;
            if (w_runt)                    runt_count <= runt_count + 1'b1;
        end
    end
`endif

endmodule
